// File: rtl/cur_block_fetch.sv
// cur_block_fetch
// Fetches one 16x16 block of 8-bit pixels (4 pixels per 32-bit word, 64 words)
// from shared frame memory and writes it into the current-block buffer.
//
// State table
//   state | meaning
//   IDLE  | waiting for start; range-checks curpos and latches the block base
//   ISSUE | presenting read requests, one word per grant, row-major order
//   DRAIN | all 64 requests granted, collecting the remaining read data
//   DONE  | buffer complete; currentfilled pulses for this one cycle
//
// Ports
//   clk, reset              clock, asynchronous active-high reset
//   start, curpos           fetch request and block index {by[13:7], bx[6:0]}
//   mem_req/addr/gnt        frame-memory read request port (arbiter owned)
//   mem_rvalid/rdata        in-order read data return
//   cb_we/addr/wdata        current-block buffer write port (addr = row*4 + col)
//   busy                    fetch in progress (ISSUE or DRAIN)
//   currentfilled           1-cycle pulse when all 64 words are written
//   range_err               1-cycle pulse after a start with an out-of-frame block
module cur_block_fetch #(
    parameter int BLK     = 16,
    parameter int FRAME_W = 1280,
    parameter int FRAME_H = 720,
    parameter int ADDR_W  = 18,
    parameter int DATA_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [13:0]       curpos,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              cb_we,
    output logic [5:0]        cb_addr,
    output logic [DATA_W-1:0] cb_wdata,
    output logic              busy,
    output logic              currentfilled,
    output logic              range_err
);

    localparam int ROW_WORDS = FRAME_W / 4;
    localparam int BLKS_X    = FRAME_W / BLK;
    localparam int BLKS_Y    = FRAME_H / BLK;

    localparam logic [ADDR_W-1:0] ROW_STRIDE = ADDR_W'(ROW_WORDS);
    localparam logic [ADDR_W-1:0] BY_STRIDE  = ADDR_W'(BLK * ROW_WORDS);
    localparam logic [ADDR_W-1:0] BX_STRIDE  = ADDR_W'(BLK / 4);
    localparam logic [6:0]        BX_LIMIT   = 7'(BLKS_X);
    localparam logic [6:0]        BY_LIMIT   = 7'(BLKS_Y);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [5:0]        iss_q, iss_d;
    logic [5:0]        rx_q, rx_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] row_q, row_d;
    logic              range_err_q, range_err_d;

    logic [6:0]        bx, by;
    logic              in_range;
    logic [ADDR_W-1:0] base;
    logic              rx_fire;

    assign bx       = curpos[6:0];
    assign by       = curpos[13:7];
    assign in_range = (bx < BX_LIMIT) && (by < BY_LIMIT);
    // Constant-coefficient products, evaluated only when a start is accepted.
    assign base     = ADDR_W'(by) * BY_STRIDE + ADDR_W'(bx) * BX_STRIDE;
    assign rx_fire  = mem_rvalid && ((state_q == ISSUE) || (state_q == DRAIN));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            iss_q       <= '0;
            rx_q        <= '0;
            addr_q      <= '0;
            row_q       <= '0;
            range_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            iss_q       <= iss_d;
            rx_q        <= rx_d;
            addr_q      <= addr_d;
            row_q       <= row_d;
            range_err_q <= range_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        iss_d       = iss_q;
        rx_d        = rx_q;
        addr_d      = addr_q;
        row_d       = row_q;
        range_err_d = 1'b0;
        mem_req     = 1'b0;

        if (rx_fire) begin
            rx_d = rx_q + 6'd1;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (in_range) begin
                        state_d = ISSUE;
                        addr_d  = base;
                        row_d   = base;
                        iss_d   = '0;
                        rx_d    = '0;
                    end else begin
                        range_err_d = 1'b1;
                    end
                end
            end
            ISSUE: begin
                mem_req = 1'b1;
                if (mem_gnt) begin
                    iss_d = iss_q + 6'd1;
                    // Last column of a row: step the row base by one frame line.
                    if (iss_q[1:0] == 2'd3) begin
                        row_d  = row_q + ROW_STRIDE;
                        addr_d = row_q + ROW_STRIDE;
                    end else begin
                        addr_d = addr_q + ADDR_W'(1);
                    end
                    if (iss_q == 6'd63) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (rx_fire && (rx_q == 6'd63)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign mem_addr      = addr_q;
    assign cb_we         = rx_fire;
    assign cb_addr       = rx_q;
    assign cb_wdata      = rx_fire ? mem_rdata : '0;
    assign busy          = (state_q == ISSUE) || (state_q == DRAIN);
    assign currentfilled = (state_q == DONE);
    assign range_err     = range_err_q;

endmodule
